regfile_wb_sched: RTL and testbench

Writeback scheduler and scoreboard for the 8x32 register file's single write port. Arbitrates up to NUM_REQ writeback requesters (e.g. ALU, load unit, multicycle unit) round-robin onto a registered write port, and tracks per-register pending-write bits so issue logic can stall on RAW/WAW hazards. Sits between the execute/memory units and the register file write port (`we`, `rd_addr`, `rd_data`).

---
 rtl/regfile_wb_sched.sv | 141 ++++++++++++++
 tb/tb_regfile_wb_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
//   Writeback scheduler and scoreboard for the register file's single write
//   port. Up to NUM_REQ writeback requesters are arbitrated round-robin onto
//   a registered write port. Per-register pending-write bits let issue logic
//   stall on RAW/WAW hazards.
//
//   Build option: define REGFILE_WB_SCOREBOARD_EN to include the scoreboard.
//   Without it there is no scoreboard storage: busy=0, claim_ready=1 outside
//   reset, and stray_wb=0.
//
// Ports
//   clk, rst_n             clock; synchronous active-low reset
//   req_valid/addr/data    per-requester writeback request (packed, i-th slice)
//   req_ready              combinational one-hot grant
//   rf_we/rd_addr/rd_data  registered register-file write port
//   grant_id               requester that drove the current rf_we cycle
//   claim_valid/addr       issue stage reserving a destination register
//   claim_ready            combinational claim acceptance
//   busy                   registered pending-write vector (bit 0 always 0)
//   stray_wb               sticky: writeback to a non-busy nonzero register
module regfile_wb_sched #(
  parameter int NUM_REQ    = 3,
  parameter int REG_COUNT  = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]         req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rf_we,
  output logic [REG_ADDR_W-1:0]         rf_rd_addr,
  output logic [31:0]                   rf_rd_data,
  output logic [1:0]                    grant_id,
  input  logic                          claim_valid,
  input  logic [REG_ADDR_W-1:0]         claim_addr,
  output logic                          claim_ready,
  output logic [REG_COUNT-1:0]          busy,
  output logic                          stray_wb
);

  logic [1:0]            last_q;
  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [31:0]           data_q;
  logic [1:0]            gid_q;

  logic                  found;
  int                    win_idx;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] win_addr;
  logic [31:0]           win_data;

  // Round-robin: search starts one past the last winner.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(last_q) + k) % NUM_REQ]) begin
        found   = 1'b1;
        win_idx = (int'(last_q) + k) % NUM_REQ;
      end
    end
  end

  assign xfer      = rst_n && found;
  assign req_ready = xfer ? (NUM_REQ'(1) << win_idx) : '0;
  assign win_addr  = req_addr[win_idx*REG_ADDR_W +: REG_ADDR_W];
  assign win_data  = req_data[win_idx*32 +: 32];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q  <= 2'(NUM_REQ - 1);
      rf_we_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      gid_q   <= '0;
    end else begin
      // r0 writes are accepted but never reach the register file.
      rf_we_q <= xfer && (win_addr != '0);
      if (xfer) begin
        addr_q <= win_addr;
        data_q <= win_data;
        gid_q  <= 2'(win_idx);
        last_q <= 2'(win_idx);
      end
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_rd_addr = addr_q;
  assign rf_rd_data = data_q;
  assign grant_id   = gid_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic                 stray_q, stray_d;
  logic                 wb_nz, claim_acc, claim_nz;

  assign wb_nz = xfer && (win_addr != '0);

  // A same-cycle writeback frees the register, so the claim may proceed.
  assign claim_ready = rst_n && ((claim_addr == '0) || !busy_q[claim_addr] ||
                                 (wb_nz && (win_addr == claim_addr)));
  assign claim_acc   = claim_valid && claim_ready;
  assign claim_nz    = claim_acc && (claim_addr != '0);

  always_comb begin
    busy_d  = busy_q;
    stray_d = stray_q;
    if (wb_nz) begin
      busy_d[win_addr] = 1'b0;
      if (!busy_q[win_addr] && !(claim_nz && (claim_addr == win_addr)))
        stray_d = 1'b1;
    end
    // Set after clear so a same-address claim keeps the bit high.
    if (claim_nz) busy_d[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= '0;
      stray_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      stray_q <= stray_d;
    end
  end

  assign busy     = busy_q;
  assign stray_wb = stray_q;
`else
  logic unused_claim;
  assign unused_claim = claim_valid ^ (^claim_addr);
  assign claim_ready  = rst_n;
  assign busy         = '0;
  assign stray_wb     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: reset state, single transfer,
// round-robin back-to-back grants, scoreboard claim/writeback interplay,
// r0 handling, stray writeback and mid-operation reset.
module tb_regfile_wb_sched;
  localparam int NR = 3;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*32-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_rd_addr;
  logic [31:0]     rf_rd_data;
  logic [1:0]      grant_id;
  logic            claim_valid;
  logic [AW-1:0]   claim_addr;
  logic            claim_ready;
  logic [7:0]      busy;
  logic            stray_wb;

  int checks = 0;
  int failures = 0;

  regfile_wb_sched #(.NUM_REQ(NR), .REG_COUNT(8), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .grant_id(grant_id),
    .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_ready(claim_ready),
    .busy(busy), .stray_wb(stray_wb)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    claim_valid = 1'b0;
    claim_addr  = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    req_valid = 3'b111;
    claim_valid = 1'b1;
    claim_addr  = 3'd4;
    step();
    step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b exp=0", rf_we); end
    checks++; if (rf_rd_addr !== 3'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", rf_rd_addr); end
    checks++; if (rf_rd_data !== 32'd0) begin failures++; $display("FAIL rst_data got=%h exp=0", rf_rd_data); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_gid got=%0d exp=0", grant_id); end
    checks++; if (busy !== 8'h00) begin failures++; $display("FAIL rst_busy got=%h exp=00", busy); end
    checks++; if (stray_wb !== 1'b0) begin failures++; $display("FAIL rst_stray got=%0b exp=0", stray_wb); end
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL rst_ready got=%b exp=000", req_ready); end
    checks++; if (claim_ready !== 1'b0) begin failures++; $display("FAIL rst_claim_ready got=%0b exp=0", claim_ready); end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    req_valid = 3'b001;
    req_addr[0*AW +: AW] = 3'd3;
    req_data[0*32 +: 32] = 32'hDEADBEEF;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL single_ready got=%b exp=001", req_ready); end
    step();
    req_valid = '0;
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL single_we got=%0b exp=1", rf_we); end
    checks++; if (rf_rd_addr !== 3'd3) begin failures++; $display("FAIL single_addr got=%0d exp=3", rf_rd_addr); end
    checks++; if (rf_rd_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", rf_rd_data); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL single_gid got=%0d exp=0", grant_id); end
    step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL single_idle_we got=%0b exp=0", rf_we); end
    checks++; if (rf_rd_addr !== 3'd3) begin failures++; $display("FAIL single_hold_addr got=%0d exp=3", rf_rd_addr); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp_rdy;
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = 3'(i + 1);
      req_data[i*32 +: 32] = 32'hA000_0000 + i;
    end
    for (int c = 0; c < 6; c++) begin
      exp_rdy = 3'b001 << (c % 3);
      #1;
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      step();
      checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL b2b_we c=%0d got=%0b exp=1", c, rf_we); end
      checks++; if (grant_id !== 2'(c % 3)) begin failures++; $display("FAIL b2b_gid c=%0d got=%0d exp=%0d", c, grant_id, c % 3); end
      checks++; if (rf_rd_data !== 32'hA000_0000 + (c % 3)) begin failures++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, rf_rd_data, 32'hA000_0000 + (c % 3)); end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_claim;
    do_reset();
    claim_valid = 1'b1; claim_addr = 3'd5;
    #1;
    checks++; if (claim_ready !== 1'b1) begin failures++; $display("FAIL claim_first_ready got=%0b exp=1", claim_ready); end
    step();
    claim_valid = 1'b0;
`ifdef REGFILE_WB_SCOREBOARD_EN
    checks++; if (busy !== 8'h20) begin failures++; $display("FAIL claim_busy got=%h exp=20", busy); end
    claim_valid = 1'b1;
    #1;
    checks++; if (claim_ready !== 1'b0) begin failures++; $display("FAIL claim_second_ready got=%0b exp=0", claim_ready); end
    step();
    claim_valid = 1'b0;
    req_valid = 3'b010;
    req_addr[1*AW +: AW] = 3'd5;
    req_data[1*32 +: 32] = 32'h0000_5555;
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL claim_wb_ready got=%b exp=010", req_ready); end
    step();
    req_valid = '0;
    checks++; if (rf_we !== 1'b1 || grant_id !== 2'd1 || rf_rd_addr !== 3'd5) begin failures++; $display("FAIL claim_wb_port we=%0b gid=%0d addr=%0d exp 1/1/5", rf_we, grant_id, rf_rd_addr); end
    checks++; if (busy !== 8'h00) begin failures++; $display("FAIL claim_wb_busy got=%h exp=00", busy); end
    checks++; if (stray_wb !== 1'b0) begin failures++; $display("FAIL claim_wb_stray got=%0b exp=0", stray_wb); end
    claim_valid = 1'b1; claim_addr = 3'd5;
    #1;
    checks++; if (claim_ready !== 1'b1) begin failures++; $display("FAIL claim_retry_ready got=%0b exp=1", claim_ready); end
    step();
    claim_valid = 1'b0;
    checks++; if (busy !== 8'h20) begin failures++; $display("FAIL claim_retry_busy got=%h exp=20", busy); end
`else
    checks++; if (busy !== 8'h00) begin failures++; $display("FAIL claim_nosb_busy got=%h exp=00", busy); end
`endif
  endtask

  task automatic test_same_cycle;
    do_reset();
    claim_valid = 1'b1; claim_addr = 3'd2;
    step();
    req_valid = 3'b001;
    req_addr[0*AW +: AW] = 3'd2;
    req_data[0*32 +: 32] = 32'h2222_2222;
    #1;
    checks++; if (claim_ready !== 1'b1) begin failures++; $display("FAIL same_claim_ready got=%0b exp=1", claim_ready); end
    step();
    clear_inputs();
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL same_we got=%0b exp=1", rf_we); end
`ifdef REGFILE_WB_SCOREBOARD_EN
    checks++; if (busy !== 8'h04) begin failures++; $display("FAIL same_busy got=%h exp=04", busy); end
`else
    checks++; if (busy !== 8'h00) begin failures++; $display("FAIL same_busy got=%h exp=00", busy); end
`endif
    checks++; if (stray_wb !== 1'b0) begin failures++; $display("FAIL same_stray got=%0b exp=0", stray_wb); end
  endtask

  // Continues from test_same_cycle: busy[2] set, last winner = 0.
  task automatic test_r0_stray;
    logic [7:0] exp_busy;
`ifdef REGFILE_WB_SCOREBOARD_EN
    exp_busy = 8'h04;
`else
    exp_busy = 8'h00;
`endif
    req_valid = 3'b001;
    req_addr[0*AW +: AW] = 3'd0;
    claim_valid = 1'b1; claim_addr = 3'd0;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL r0_ready got=%b exp=001", req_ready); end
    checks++; if (claim_ready !== 1'b1) begin failures++; $display("FAIL r0_claim_ready got=%0b exp=1", claim_ready); end
    step();
    clear_inputs();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL r0_we got=%0b exp=0", rf_we); end
    checks++; if (busy !== exp_busy) begin failures++; $display("FAIL r0_busy got=%h exp=%h", busy, exp_busy); end
    req_valid = 3'b100;
    req_addr[2*AW +: AW] = 3'd6;
    req_data[2*32 +: 32] = 32'h6666_6666;
    step();
    clear_inputs();
    checks++; if (rf_we !== 1'b1 || rf_rd_addr !== 3'd6 || grant_id !== 2'd2) begin failures++; $display("FAIL stray_port we=%0b addr=%0d gid=%0d exp 1/6/2", rf_we, rf_rd_addr, grant_id); end
    step();
    step();
`ifdef REGFILE_WB_SCOREBOARD_EN
    checks++; if (stray_wb !== 1'b1) begin failures++; $display("FAIL stray_sticky got=%0b exp=1", stray_wb); end
`else
    checks++; if (stray_wb !== 1'b0) begin failures++; $display("FAIL stray_nosb got=%0b exp=0", stray_wb); end
`endif
    do_reset();
    checks++; if (stray_wb !== 1'b0) begin failures++; $display("FAIL stray_cleared got=%0b exp=0", stray_wb); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    claim_valid = 1'b1; claim_addr = 3'd2;
    step();
    claim_addr = 3'd3;
    step();
    claim_valid = 1'b0;
`ifdef REGFILE_WB_SCOREBOARD_EN
    checks++; if (busy !== 8'h0C) begin failures++; $display("FAIL mid_busy_pre got=%h exp=0c", busy); end
`endif
    req_valid = 3'b100;
    req_addr[2*AW +: AW] = 3'd7;
    req_data[2*32 +: 32] = 32'h7777_7777;
    step();
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL mid_inflight_we got=%0b exp=1", rf_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL mid_ready_in_rst got=%b exp=000", req_ready); end
    step();
    checks++; if (busy !== 8'h00) begin failures++; $display("FAIL mid_busy got=%h exp=00", busy); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mid_we got=%0b exp=0", rf_we); end
    rst_n = 1'b1;
    req_valid = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL mid_restart0 got=%b exp=001", req_ready); end
    step();
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL mid_restart1 got=%b exp=010", req_ready); end
    clear_inputs();
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_claim();
    test_same_cycle();
    test_r0_stray();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
